// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: divides MCLK into SCLK/LRCK and hands held stereo words to the encoder.
// Build option I2S_UNDERRUN_REPEAT_EN: repeat the previous words on underrun instead of muting.
module i2s_tx_sequencer #(
  parameter int RESOLUTION = 24,
  parameter int SCLK_DIV   = 4,
  parameter int SLOT_BITS  = 32
) (
  input  logic                  MCLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [RESOLUTION-1:0] s_data_L,
  input  logic [RESOLUTION-1:0] s_data_R,
  output logic                  SCLK,
  output logic                  LRCK,
  output logic [RESOLUTION-1:0] data_out_L,
  output logic [RESOLUTION-1:0] data_out_R,
  output logic                  frame_start,
  output logic [15:0]           underrun_count
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_HALF = BIT_W'(SLOT_BITS);

`ifdef I2S_UNDERRUN_REPEAT_EN
  localparam logic MUTE_ON_UNDERRUN = 1'b0;
`else
  localparam logic MUTE_ON_UNDERRUN = 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [RESOLUTION-1:0]   pend_L;
  logic [RESOLUTION-1:0]   pend_R;
  logic                    pend_valid;

  logic [DIV_W-1:0]        div_nxt;
  logic [BIT_W-1:0]        bit_nxt;
  logic                    div_wrap;
  logic                    frame_wrap;
  logic                    load_pt;
  logic                    handshake;
  logic                    pend_nxt;

  always_comb begin
    div_wrap   = (div_cnt == DIV_LAST);
    div_nxt    = div_wrap ? '0 : div_cnt + 1'b1;
    bit_nxt    = bit_cnt;
    if (div_wrap) begin
      bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
    frame_wrap = div_wrap && (bit_cnt == BIT_LAST);
    // SCLK rising edge inside the last (padding) bit of the right slot
    load_pt    = (bit_cnt == BIT_LAST) && (div_nxt == DIV_HALF);
    handshake  = s_valid && s_ready;
    pend_nxt   = pend_valid;
    if (handshake) begin
      pend_nxt = 1'b1;
    end else if (load_pt && pend_valid) begin
      pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      SCLK           <= 1'b0;
      LRCK           <= 1'b0;
      data_out_L     <= '0;
      data_out_R     <= '0;
      pend_L         <= '0;
      pend_R         <= '0;
      pend_valid     <= 1'b0;
      s_ready        <= 1'b0;
      frame_start    <= 1'b0;
      underrun_count <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt    <= '0;
          bit_cnt    <= '0;
          SCLK       <= 1'b0;
          LRCK       <= 1'b0;
          pend_valid <= 1'b0;
          s_ready    <= enable;
          if (enable) begin
            state <= PRIME;
          end
        end

        PRIME: begin
          // A visible s_ready has already been offered, so a handshake wins over enable dropping
          if (handshake) begin
            data_out_L  <= s_data_L;
            data_out_R  <= s_data_R;
            frame_start <= 1'b1;
            state       <= RUN;
          end else if (!enable) begin
            s_ready <= 1'b0;
            state   <= IDLE;
          end
        end

        RUN: begin
          div_cnt <= div_nxt;
          bit_cnt <= bit_nxt;
          SCLK    <= (div_nxt >= DIV_HALF);
          LRCK    <= (bit_nxt >= SLOT_HALF);

          if (load_pt) begin
            if (pend_valid) begin
              data_out_L <= pend_L;
              data_out_R <= pend_R;
            end else begin
              if (underrun_count != '1) begin
                underrun_count <= underrun_count + 16'd1;
              end
              if (MUTE_ON_UNDERRUN) begin
                data_out_L <= '0;
                data_out_R <= '0;
              end
            end
          end

          if (handshake) begin
            pend_L <= s_data_L;
            pend_R <= s_data_R;
          end

          if (frame_wrap && !enable) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            s_ready    <= 1'b0;
          end else begin
            pend_valid  <= pend_nxt;
            s_ready     <= !pend_nxt;
            frame_start <= frame_wrap;
          end
        end

        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed self-checking bench for i2s_tx_sequencer at default parameters (256 MCLK per frame).
module tb_i2s_tx_sequencer;

  logic        MCLK;
  logic        RST;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data_L;
  logic [23:0] s_data_R;
  logic        SCLK;
  logic        LRCK;
  logic [23:0] data_out_L;
  logic [23:0] data_out_R;
  logic        frame_start;
  logic [15:0] underrun_count;

  int          errors;
  int          checks;
  int          k;
  logic [23:0] exp_L;
  logic [23:0] exp_R;

  i2s_tx_sequencer #(
    .RESOLUTION(24),
    .SCLK_DIV(4),
    .SLOT_BITS(32)
  ) dut (
    .MCLK(MCLK),
    .RST(RST),
    .enable(enable),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data_L(s_data_L),
    .s_data_R(s_data_R),
    .SCLK(SCLK),
    .LRCK(LRCK),
    .data_out_L(data_out_L),
    .data_out_R(data_out_R),
    .frame_start(frame_start),
    .underrun_count(underrun_count)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // k counts MCLK cycles since the frame began; cycle 0 is the one right after accept
  task automatic step();
    tick();
    k++;
    check("sclk", 32'(SCLK), 32'((k % 4) >= 2));
    check("lrck", 32'(LRCK), 32'((k % 256) >= 128));
    check("frame_start", 32'(frame_start), 32'((k % 256) == 0));
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic check_data(input string tag);
    check({tag, "_L"}, 32'(data_out_L), 32'(exp_L));
    check({tag, "_R"}, 32'(data_out_R), 32'(exp_R));
  endtask

  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    s_valid  = 1'b1;
    s_data_L = l;
    s_data_R = r;
    step();
    s_valid  = 1'b0;
  endtask

  task automatic set_exp(input logic [23:0] l, input logic [23:0] r);
    exp_L = l;
    exp_R = r;
  endtask

  initial begin
    errors = 0; checks = 0; k = 0;
    RST = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data_L = '0; s_data_R = '0;
    set_exp(24'h0, 24'h0);
    tick(); tick();
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_lrck", 32'(LRCK), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_under", 32'(underrun_count), 32'd0);
    check_data("rst_data");

    RST = 1'b0;
    tick();
    check("idle_ready", 32'(s_ready), 32'd0);

    // PRIME with nothing offered
    enable = 1'b1;
    repeat (5) tick();
    check("prime_ready", 32'(s_ready), 32'd1);
    check("prime_sclk", 32'(SCLK), 32'd0);
    check("prime_lrck", 32'(LRCK), 32'd0);
    check("prime_under", 32'(underrun_count), 32'd0);

    // accept the first pair directly into data_out
    s_valid = 1'b1; s_data_L = 24'h123456; s_data_R = 24'hABCDEF;
    tick();
    s_valid = 1'b0; k = 0;
    set_exp(24'h123456, 24'hABCDEF);
    check_data("accept");
    check("accept_fs", 32'(frame_start), 32'd1);
    check("accept_lrck", 32'(LRCK), 32'd0);
    check("accept_sclk", 32'(SCLK), 32'd0);
    check("accept_ready", 32'(s_ready), 32'd1);

    run_to(100);
    offer(24'h111111, 24'h222222);
    check("pend_full_ready", 32'(s_ready), 32'd0);
    run_to(253);
    check_data("before_load0");
    step();
    set_exp(24'h111111, 24'h222222);
    check_data("load0");
    check("load0_ready", 32'(s_ready), 32'd1);
    check("load0_under", 32'(underrun_count), 32'd0);

    run_to(306);
    offer(24'h000001, 24'h000002);
    check("pend2_ready", 32'(s_ready), 32'd0);
    run_to(509);
    check_data("before_load1");
    step();
    set_exp(24'h000001, 24'h000002);
    check_data("load1");
    check("load1_under", 32'(underrun_count), 32'd0);

    // feeding stops: one underrun per frame
    run_to(765);
    check_data("before_ur1");
    check("before_ur1_cnt", 32'(underrun_count), 32'd0);
    step();
`ifndef I2S_UNDERRUN_REPEAT_EN
    set_exp(24'h0, 24'h0);
`endif
    check_data("ur1");
    check("ur1_cnt", 32'(underrun_count), 32'd1);
    run_to(1022);
    check_data("ur2");
    check("ur2_cnt", 32'(underrun_count), 32'd2);

    // handshake on the load edge with pend empty: goes to pend, load still underruns
    run_to(1277);
    offer(24'h0A0B0C, 24'h0D0E0F);
    check("coinc_cnt", 32'(underrun_count), 32'd3);
    check_data("coinc");
    check("coinc_ready", 32'(s_ready), 32'd0);
    run_to(1533);
    check_data("before_coinc_load");
    step();
    set_exp(24'h0A0B0C, 24'h0D0E0F);
    check_data("coinc_load");
    check("coinc_load_cnt", 32'(underrun_count), 32'd3);
    check("coinc_load_ready", 32'(s_ready), 32'd1);

    // saturation from a preloaded count
    run_to(1600);
    force dut.underrun_count = 16'hFFFD;
    step();
    release dut.underrun_count;
    check("preload", 32'(underrun_count), 32'h0000FFFD);
    run_to(1790);
`ifndef I2S_UNDERRUN_REPEAT_EN
    set_exp(24'h0, 24'h0);
`endif
    check("sat_fffe", 32'(underrun_count), 32'h0000FFFE);
    check_data("sat_data");
    run_to(2046);
    check("sat_ffff", 32'(underrun_count), 32'h0000FFFF);
    run_to(2302);
    check("sat_hold", 32'(underrun_count), 32'h0000FFFF);

    // drop enable at bit_cnt 10; frame runs to its end
    run_to(2344);
    enable = 1'b0;
    run_to(2558);
    check("stop_ready", 32'(s_ready), 32'd1);
    offer(24'h777777, 24'h888888);
    check("stop_pend_ready", 32'(s_ready), 32'd0);
    tick();
    check("idle_sclk", 32'(SCLK), 32'd0);
    check("idle_lrck", 32'(LRCK), 32'd0);
    check("idle_ready2", 32'(s_ready), 32'd0);
    check("idle_cnt", 32'(underrun_count), 32'h0000FFFF);
    check_data("idle_hold");
    repeat (10) tick();
    check("idle_sclk2", 32'(SCLK), 32'd0);
    check("idle_lrck2", 32'(LRCK), 32'd0);

    // restart: the stale pend pair must not reappear
    enable = 1'b1;
    tick(); tick();
    check("reprime_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_data_L = 24'h555555; s_data_R = 24'h666666;
    tick();
    s_valid = 1'b0; k = 0;
    set_exp(24'h555555, 24'h666666);
    check_data("reaccept");
    check("reaccept_fs", 32'(frame_start), 32'd1);
    run_to(253);
    check_data("before_reload");
    step();
`ifndef I2S_UNDERRUN_REPEAT_EN
    set_exp(24'h0, 24'h0);
`endif
    check_data("stale_pend");

    // asynchronous reset mid-frame with SCLK and LRCK both high
    run_to(386);
    RST = 1'b1;
    #1;
    set_exp(24'h0, 24'h0);
    check("arst_sclk", 32'(SCLK), 32'd0);
    check("arst_lrck", 32'(LRCK), 32'd0);
    check("arst_ready", 32'(s_ready), 32'd0);
    check("arst_fs", 32'(frame_start), 32'd0);
    check("arst_cnt", 32'(underrun_count), 32'd0);
    check_data("arst_data");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
